// File: rtl/lcd_frame_streamer.sv
// Streams a 2x16 HD44780 character frame from a local buffer to the LCD bus executor.
// Define LCD_STREAM_INIT_EN to send the display init sequence before the first frame after reset.
module lcd_frame_streamer #(
  parameter logic [7:0] INIT_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       refresh,
  input  logic       exe_rdy,
  output logic       exe_valid,
  output logic [3:0] exe_op,
  output logic [7:0] exe_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DEPTH     = 32;
  localparam int unsigned CHAR_W    = 8;
  localparam logic [3:0]  OP_INSTR  = 4'd1;
  localparam logic [3:0]  OP_DATA   = 4'd2;
  localparam logic [3:0]  IDX_LAST  = 4'd15;
  localparam logic [7:0]  CMD_LINE1 = 8'h80;
  localparam logic [7:0]  CMD_LINE2 = 8'hC0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef LCD_STREAM_INIT_EN
    S_INIT  = 3'd1,
`endif
    S_CMD1  = 3'd2,
    S_LINE1 = 3'd3,
    S_CMD2  = 3'd4,
    S_LINE2 = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t                       state;
  logic [3:0]                   idx;
  logic [3:0]                   idx_nx;
  logic                         pending;
  logic                         xfer;
  logic [DEPTH-1:0][CHAR_W-1:0] frame_buf;

`ifdef LCD_STREAM_INIT_EN
  logic [1:0] init_idx;
  logic       init_done;

  // Function set 8-bit/2-line, display on, entry increment, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction
`endif

  assign xfer   = exe_valid && exe_rdy;
  assign idx_nx = 4'(idx + 4'd1);

  // Character store; writes land in any state, reset restores blanks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_buf <= {DEPTH{INIT_CHAR}};
    end else if (wr_en) begin
      frame_buf[wr_addr] <= wr_char;
    end
  end

  // Sequencer: the offered byte is latched from the buffer at the edge it is presented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      pending   <= 1'b0;
      exe_valid <= 1'b0;
      exe_op    <= 4'd0;
      exe_data  <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LCD_STREAM_INIT_EN
      init_idx  <= 2'd0;
      init_done <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (busy && refresh) begin
        pending <= 1'b1;
      end

      case (state)
        S_IDLE, S_FIN: begin
          exe_valid <= 1'b0;
          exe_op    <= 4'd0;
          exe_data  <= 8'd0;
          busy      <= 1'b0;
          state     <= S_IDLE;
          // FIN launches exactly like IDLE so back-to-back frames have no gap.
          if (refresh || pending) begin
            pending   <= 1'b0;
            busy      <= 1'b1;
            exe_valid <= 1'b1;
            exe_op    <= OP_INSTR;
`ifdef LCD_STREAM_INIT_EN
            if (!init_done) begin
              state    <= S_INIT;
              init_idx <= 2'd0;
              exe_data <= init_cmd(2'd0);
            end else begin
              state    <= S_CMD1;
              exe_data <= CMD_LINE1;
            end
`else
            state    <= S_CMD1;
            exe_data <= CMD_LINE1;
`endif
          end
        end

`ifdef LCD_STREAM_INIT_EN
        S_INIT: begin
          if (xfer) begin
            if (init_idx == 2'd3) begin
              state     <= S_CMD1;
              exe_data  <= CMD_LINE1;
              init_done <= 1'b1;
            end else begin
              init_idx <= 2'(init_idx + 2'd1);
              exe_data <= init_cmd(2'(init_idx + 2'd1));
            end
          end
        end
`endif

        S_CMD1: begin
          if (xfer) begin
            state    <= S_LINE1;
            idx      <= 4'd0;
            exe_op   <= OP_DATA;
            exe_data <= frame_buf[5'd0];
          end
        end

        S_LINE1: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              state    <= S_CMD2;
              exe_op   <= OP_INSTR;
              exe_data <= CMD_LINE2;
            end else begin
              idx      <= idx_nx;
              exe_data <= frame_buf[{1'b0, idx_nx}];
            end
          end
        end

        S_CMD2: begin
          if (xfer) begin
            state    <= S_LINE2;
            idx      <= 4'd0;
            exe_op   <= OP_DATA;
            exe_data <= frame_buf[5'd16];
          end
        end

        S_LINE2: begin
          if (xfer) begin
            if (idx == IDX_LAST) begin
              state     <= S_FIN;
              idx       <= 4'd0;
              exe_valid <= 1'b0;
              exe_op    <= 4'd0;
              exe_data  <= 8'd0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= idx_nx;
              exe_data <= frame_buf[{1'b1, idx_nx}];
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          exe_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Self-checking bench for lcd_frame_streamer: vector table, directed frame scenarios,
// and randomized traffic against a transfer-position reference model.
module tb_lcd_frame_streamer;

`ifdef LCD_STREAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       refresh;
  logic       exe_rdy;
  logic       exe_valid;
  logic [3:0] exe_op;
  logic [7:0] exe_data;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lcd_frame_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .refresh   (refresh),
    .exe_rdy   (exe_rdy),
    .exe_valid (exe_valid),
    .exe_op    (exe_op),
    .exe_data  (exe_data),
    .busy      (busy),
    .done      (done)
  );

  // Reference model: a frame is a list of transfers indexed by position.
  logic [7:0]  m_buf [32];
  bit          m_active, m_pending, m_done, m_init, m_init_done;
  int          m_pos;
  logic [11:0] m_item;
  logic [11:0] xfers [$];

  function automatic logic [11:0] frame_item(input int pos, input bit with_init);
    int p;
    p = with_init ? pos - 4 : pos;
    if (p < 0) begin
      case (pos)
        0:       return {4'd1, 8'h38};
        1:       return {4'd1, 8'h0C};
        2:       return {4'd1, 8'h06};
        default: return {4'd1, 8'h01};
      endcase
    end
    if (p == 0)  return {4'd1, 8'h80};
    if (p <= 16) return {4'd2, m_buf[p-1]};
    if (p == 17) return {4'd1, 8'hC0};
    return {4'd2, m_buf[p-2]};
  endfunction

  function automatic int frame_len(input bit with_init);
    return with_init ? 38 : 34;
  endfunction

  task automatic model_edge(input bit r, input bit rf, input bit rdy, input bit we,
                            input logic [4:0] wa, input logic [7:0] wc);
    m_done = 1'b0;
    if (!r) begin
      m_active = 0; m_pending = 0; m_init = 0; m_init_done = 0; m_pos = 0;
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    end else begin
      if (m_active) begin
        if (rf) m_pending = 1'b1;
        if (rdy) begin
          m_pos++;
          if (m_init && m_pos == 4) m_init_done = 1'b1;
          if (m_pos == frame_len(m_init)) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end else begin
            m_item = frame_item(m_pos, m_init);
          end
        end
      end else if (rf || m_pending) begin
        m_active  = 1'b1;
        m_pending = 1'b0;
        m_pos     = 0;
        m_init    = INIT_EN && !m_init_done;
        m_item    = frame_item(0, m_init);
      end
      if (we) m_buf[wa] = wc;
    end
  endtask

  task automatic chk(input string name, input bit ok, input string got, input string want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s @%0t: got %s, want %s", name, $time, got, want);
    end
  endtask

  // One clock: drive inputs, log any handshake, advance the model, compare outputs.
  task automatic cyc(input bit r, input bit rf, input bit rdy, input bit we,
                     input logic [4:0] wa, input logic [7:0] wc);
    bit ok;
    rst = r; refresh = rf; exe_rdy = rdy; wr_en = we; wr_addr = wa; wr_char = wc;
    if (exe_valid === 1'b1 && rdy) xfers.push_back({exe_op, exe_data});
    @(posedge clk);
    model_edge(r, rf, rdy, we, wa, wc);
    #1;
    ok = (exe_valid === m_active) && (busy === m_active) && (done === m_done) &&
         (!m_active || (exe_op === m_item[11:8] && exe_data === m_item[7:0]));
    chk("model", ok,
        $sformatf("v=%b op=%0d d=%h busy=%b done=%b", exe_valid, exe_op, exe_data, busy, done),
        $sformatf("v=%b op=%0d d=%h busy=%b done=%b", m_active, m_item[11:8], m_item[7:0],
                  m_active, m_done));
  endtask

  // Whole frame with exe_rdy high, optionally stalling 5 cycles before iteration stall_at.
  task automatic run_frame(input string tag, input int stall_at, input logic [7:0] stall_data,
                           output int done_cyc);
    logic [11:0] exp_q [$];
    bit          wi;
    int          flen;
    wi   = INIT_EN && !m_init_done;
    flen = frame_len(wi);
    for (int p = 0; p < flen; p++) exp_q.push_back(frame_item(p, wi));
    xfers.delete();
    done_cyc = -1;
    cyc(1, 1, 1, 0, 5'd0, 8'd0);
    for (int k = 1; k < 80 && done_cyc < 0; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          cyc(1, 0, 0, 0, 5'd0, 8'd0);
          chk({tag, " stall hold"}, exe_valid === 1'b1 && exe_op === 4'd2 && exe_data === stall_data,
              $sformatf("v=%b op=%0d d=%h", exe_valid, exe_op, exe_data),
              $sformatf("v=1 op=2 d=%h", stall_data));
        end
      end
      cyc(1, 0, 1, 0, 5'd0, 8'd0);
      if (done === 1'b1) done_cyc = k + 1;
    end
    chk({tag, " done seen"}, done_cyc > 0, $sformatf("%0d", done_cyc), "done pulse");
    chk({tag, " count"}, xfers.size() == flen, $sformatf("%0d", xfers.size()), $sformatf("%0d", flen));
    for (int p = 0; p < flen && p < xfers.size(); p++) begin
      if (xfers[p] !== exp_q[p])
        chk($sformatf("%s item %0d", tag, p), 1'b0, $sformatf("%h", xfers[p]), $sformatf("%h", exp_q[p]));
    end
  endtask

  typedef struct {
    bit         r, rf, rdy, we;
    logic [4:0] wa;
    logic [7:0] wc;
    bit         v;
    logic [3:0] op;
    logic [7:0] d;
    bit         b, dn;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int          dcyc, dn_cnt, off;
    bit          dseen, r, rf, rdy, we;
    logic [7:0]  first_byte;

    rst = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_char = 8'd0; refresh = 1'b0; exe_rdy = 1'b0;

`ifdef LCD_STREAM_INIT_EN
    tbl[3] = '{1,1,0,0, 5'd0, 8'h00,  1, 4'd1, 8'h38, 1, 0};
    tbl[4] = '{1,0,0,0, 5'd0, 8'h00,  1, 4'd1, 8'h38, 1, 0};
    tbl[5] = '{1,0,1,0, 5'd0, 8'h00,  1, 4'd1, 8'h0C, 1, 0};
    tbl[6] = '{1,0,1,1, 5'd1, 8'h51,  1, 4'd1, 8'h06, 1, 0};
    tbl[7] = '{1,0,1,1, 5'd3, 8'h33,  1, 4'd1, 8'h01, 1, 0};
    tbl[8] = '{1,0,1,0, 5'd0, 8'h00,  1, 4'd1, 8'h80, 1, 0};
`else
    tbl[3] = '{1,1,0,0, 5'd0, 8'h00,  1, 4'd1, 8'h80, 1, 0};
    tbl[4] = '{1,0,0,0, 5'd0, 8'h00,  1, 4'd1, 8'h80, 1, 0};
    tbl[5] = '{1,0,1,0, 5'd0, 8'h00,  1, 4'd2, 8'h20, 1, 0};
    tbl[6] = '{1,0,1,1, 5'd1, 8'h51,  1, 4'd2, 8'h20, 1, 0};
    tbl[7] = '{1,0,1,1, 5'd3, 8'h33,  1, 4'd2, 8'h20, 1, 0};
    tbl[8] = '{1,0,1,0, 5'd0, 8'h00,  1, 4'd2, 8'h33, 1, 0};
`endif
    tbl[0] = '{0,0,0,0, 5'd0, 8'h00,  0, 4'd0, 8'h00, 0, 0};
    tbl[1] = '{0,1,1,0, 5'd0, 8'h00,  0, 4'd0, 8'h00, 0, 0};
    tbl[2] = '{1,0,1,0, 5'd0, 8'h00,  0, 4'd0, 8'h00, 0, 0};
    tbl[9] = '{0,0,0,0, 5'd0, 8'h00,  0, 4'd0, 8'h00, 0, 0};

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].rf, tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wc);
      chk($sformatf("table row %0d", i),
          exe_valid === tbl[i].v && exe_op === tbl[i].op && exe_data === tbl[i].d &&
          busy === tbl[i].b && done === tbl[i].dn,
          $sformatf("v=%b op=%0d d=%h b=%b dn=%b", exe_valid, exe_op, exe_data, busy, done),
          $sformatf("v=%b op=%0d d=%h b=%b dn=%b", tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].b, tbl[i].dn));
    end

    // Default frame straight out of reset.
    run_frame("default frame", -1, 8'h00, dcyc);
    chk("done latency", dcyc == frame_len(INIT_EN) + 1, $sformatf("%0d", dcyc),
        $sformatf("%0d", frame_len(INIT_EN) + 1));

    // Addressed writes at the line edges.
    cyc(1, 0, 0, 1, 5'd0,  8'h41);
    cyc(1, 0, 0, 1, 5'd15, 8'h5A);
    cyc(1, 0, 0, 1, 5'd16, 8'h30);
    cyc(1, 0, 0, 1, 5'd31, 8'h39);
    run_frame("addressed", -1, 8'h00, dcyc);
    chk("pos 2",  xfers[1][7:0]  === 8'h41, $sformatf("%h", xfers[1][7:0]),  "41");
    chk("pos 17", xfers[16][7:0] === 8'h5A, $sformatf("%h", xfers[16][7:0]), "5a");
    chk("pos 19", xfers[18][7:0] === 8'h30, $sformatf("%h", xfers[18][7:0]), "30");
    chk("pos 34", xfers[33][7:0] === 8'h39, $sformatf("%h", xfers[33][7:0]), "39");

    // Backpressure while buf[7] is offered.
    cyc(1, 0, 0, 1, 5'd7, 8'h37);
    cyc(1, 0, 0, 1, 5'd8, 8'h38);
    run_frame("backpressure", 9, 8'h37, dcyc);

    // Three refresh pulses while busy collapse into one extra frame.
    xfers.delete();
    dn_cnt = 0;
    cyc(1, 1, 1, 0, 5'd0, 8'd0);
    for (int k = 1; k < 150; k++) begin
      cyc(1, (k == 5 || k == 10 || k == 15), 1, 0, 5'd0, 8'd0);
      if (done === 1'b1) dn_cnt++;
    end
    chk("coalesce done pulses", dn_cnt == 2, $sformatf("%0d", dn_cnt), "2");
    chk("coalesce transfers", xfers.size() == 68, $sformatf("%0d", xfers.size()), "68");

    // Refresh on the FIN cycle restarts with no idle cycle.
    cyc(1, 1, 1, 0, 5'd0, 8'd0);
    dseen = 1'b0;
    for (int k = 0; k < 60 && !dseen; k++) begin
      cyc(1, 0, 1, 0, 5'd0, 8'd0);
      dseen = (done === 1'b1);
    end
    chk("fin reached", dseen, $sformatf("%b", dseen), "1");
    cyc(1, 1, 0, 0, 5'd0, 8'd0);
    chk("fin restart", exe_valid === 1'b1 && exe_op === 4'd1 && exe_data === 8'h80 && busy === 1'b1,
        $sformatf("v=%b op=%0d d=%h b=%b", exe_valid, exe_op, exe_data, busy), "v=1 op=1 d=80 b=1");
    dseen = 1'b0;
    for (int k = 0; k < 60 && !dseen; k++) begin
      cyc(1, 0, 1, 0, 5'd0, 8'd0);
      dseen = (done === 1'b1);
    end

    // Reset in the middle of a frame.
    cyc(1, 0, 0, 1, 5'd20, 8'h55);
    cyc(1, 1, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < 9; k++) cyc(1, 0, 1, 0, 5'd0, 8'd0);
    cyc(0, 0, 1, 0, 5'd0, 8'd0);
    chk("midframe reset", exe_valid === 1'b0 && busy === 1'b0,
        $sformatf("v=%b b=%b", exe_valid, busy), "v=0 b=0");
    run_frame("after reset", -1, 8'h00, dcyc);
    first_byte = INIT_EN ? 8'h38 : 8'h80;
    off        = INIT_EN ? 4 : 0;
    chk("restart first", xfers[0] === {4'd1, first_byte}, $sformatf("%h", xfers[0]),
        $sformatf("1%h", first_byte));
    chk("entry 20 blank", xfers[off+22][7:0] === 8'h20, $sformatf("%h", xfers[off+22][7:0]), "20");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(999) >= 3);
      rf  = ($urandom_range(99) < 3);
      rdy = ($urandom_range(99) < 70);
      we  = ($urandom_range(99) < 30);
      cyc(r, rf, rdy, we, 5'($urandom_range(31)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/lcd_frame_streamer.md
# lcd_frame_streamer

- Holds a 2×16 character frame buffer for the HD44780 display path.
- Sits between the command/formatting stage and the LCD bus executor. The upstream stage writes characters into the buffer by address; the executor consumes the stream.
- On a refresh request the block emits a fixed transfer sequence to the executor over a valid/ready handshake: line-1 address command, 16 characters, line-2 address command, 16 characters.

## Interface
- `INIT_CHAR`, default `8'h20`: value loaded into every buffer entry at reset (ASCII space).
- `clk`  in  1: rising-edge clock, same domain as the executor.
- `rst`  in  1: reset, synchronous, active-low.
- `wr_en`  in  1: write strobe for one buffer entry.
- `wr_addr`  in  5: entry index. 0–15 is line 1, 16–31 is line 2.
- `wr_char`  in  8: character code to store.
- `refresh`  in  1: request to stream the full frame. Level, sampled each cycle.
- `exe_rdy`  in  1: executor can accept a transfer.
- `exe_valid`  out  1: transfer offered.
- `exe_op`  out  4: `4'd1` means instruction write (RS=0); `4'd2` means data write (RS=1).
- `exe_data`  out  8: instruction byte or character.
- `busy`  out  1: high from acceptance of a refresh until the final transfer completes.
- `done`  out  1: one-cycle pulse after a frame completes.

## Operation
- **Buffer:** 32×8 registers.
  - A write with `wr_en=1` updates entry `wr_addr` at the clock edge, in any state.
  - The streamed byte is read from the buffer as it stands when the transfer is presented.
- **States:** IDLE, INIT (macro only), CMD1, LINE1, CMD2, LINE2, FIN.
  - IDLE: if `refresh=1` or `pending=1`, go to CMD1 (or INIT, see Configuration). Clear `pending`. Set `busy=1`.
  - CMD1: offer op 1, data `8'h80`.
  - LINE1: offer op 2, data `buf[idx]`, with `idx` running 0..15.
  - CMD2: offer op 1, data `8'hC0`.
  - LINE2: offer op 2, data `buf[16+idx]`, with `idx` running 0..15.
  - FIN: `done=1` and `busy=0` for one cycle, then return to IDLE.
- **Handshake:**
  - A transfer completes on a cycle where `exe_valid && exe_rdy`.
  - Once `exe_valid` is asserted, `exe_valid`, `exe_op` and `exe_data` stay stable until the transfer completes.
  - The state or index advances only on completion.
- **Counter:** `idx` is 4 bits and resets to 0 on entry to LINE1 and LINE2. At `idx=15` a completion moves LINE1 to CMD2 and LINE2 to FIN; there is no wrap inside a line.
- **Refresh while busy:** sets the single `pending` flag. Exactly one further frame follows FIN. Any number of requests collapse into that one frame.
- **Write during streaming:**
  - Entries not yet offered show the new value in the current frame.
  - The entry currently offered keeps its latched byte until accepted.
- **Reset** (`rst=0` at an edge), from any state, including mid-frame:
  - state goes to IDLE; `idx` and `pending` clear;
  - all buffer entries load `INIT_CHAR`;
  - the INIT-done flag clears.
  - A half-sent frame is abandoned.

## Timing
- **Reset values:** `exe_valid=0`, `exe_op=0`, `exe_data=0`, `busy=0`, `done=0`.
- **Start latency:** `refresh` sampled high in IDLE at edge N gives `busy=1` and `exe_valid=1` (`8'h80`) from edge N+1.
- **Throughput:** one transfer per cycle while `exe_rdy` is held high. A frame is 34 transfers.
- **Completion:** `done` goes high the cycle after the last LINE2 completion. `busy` falls in the same cycle.
- **Refresh on the FIN cycle:** taken as a new request. CMD1 starts on the next edge, with no idle cycle in between.
- **Write and offer in the same cycle, same entry:** the old byte is offered. The new byte is stored for later frames.

## Configuration
- **Macro:** `LCD_STREAM_INIT_EN`.
- **Defined:** the first frame after reset is preceded by INIT, which issues four op-1 transfers: `8'h38`, `8'h0C`, `8'h06`, `8'h01`. It then sets the INIT-done flag. Later frames skip INIT. A frame with INIT is 38 transfers.
- **Undefined:** the INIT state and flag are absent. Every frame starts at CMD1.

## Test plan
- **Reset and default frame:** reset, then one `refresh` pulse with `exe_rdy=1`. Expect 34 transfers: `(1,80)`, 16×`(2,20)`, `(1,C0)`, 16×`(2,20)`. Expect `done` on cycle 35 after start.
- **Addressed writes:** write `8'h41` at addr 0, `8'h5A` at 15, `8'h30` at 16, `8'h39` at 31, then refresh. Expect those bytes at transfer positions 2, 17, 19 and 34.
- **Backpressure:** hold `exe_rdy=0` for 5 cycles mid-LINE1 at `idx=7`. Expect `exe_valid=1` and `exe_data=buf[7]` held stable, then resume with no skipped or duplicated byte.
- **Refresh coalescing:** pulse `refresh` three times while busy. Expect exactly two frames and two `done` pulses.
- **Reset mid-frame:** apply `rst=0` at transfer 10. Next cycle expect `exe_valid=0`, `busy=0` and all entries `8'h20`. A fresh refresh then restarts at `(1,80)`.
- **With `LCD_STREAM_INIT_EN`:** the first frame begins `(1,38)`, `(1,0C)`, `(1,06)`, `(1,01)`, `(1,80)` and has 38 transfers. The second frame has 34 transfers and starts `(1,80)`.
